// File: rtl/sequence_generator.sv
// sequence_generator: framed serial stimulus source emitting 0,1,0^N,1 per
// accepted request, one bit per enabled clock, with a saturating frame count.
// Optional 7-segment display outputs are enabled by defining SEQGEN_DISP_EN.
module sequence_generator #(
    parameter int unsigned ZW    = 4,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             req,
    input  logic [ZW-1:0]    n_zeros,
    output logic             sig_out,
    output logic             ack,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt
`ifdef SEQGEN_DISP_EN
    ,
    output logic [7:0]       disp0,
    output logic [7:0]       disp1
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(99);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD0 = 3'd1,
        LEAD1 = 3'd2,
        ZEROS = 3'd3,
        FINAL = 3'd4
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [ZW-1:0]    n_lat;
    logic [ZW-1:0]    n_lat_d;
    logic [ZW-1:0]    zcnt;
    logic [ZW-1:0]    zcnt_d;
    logic             sig_d;
    logic             ack_d;
    logic             busy_d;
    logic             done_d;
    logic [CNT_W-1:0] frame_cnt_d;

    // Next-state, latched frame length, zero counter and registered-output inputs
    always_comb begin
        state_d     = state;
        n_lat_d     = n_lat;
        zcnt_d      = zcnt;
        ack_d       = 1'b0;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt;

        if (ena) begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state_d = LEAD0;
                        n_lat_d = n_zeros;
                        ack_d   = 1'b1;
                    end
                end
                LEAD0: begin
                    state_d = LEAD1;
                end
                LEAD1: begin
                    if (n_lat == '0) begin
                        state_d = FINAL;
                    end else begin
                        state_d = ZEROS;
                        zcnt_d  = n_lat - ZW'(1);
                    end
                end
                ZEROS: begin
                    if (zcnt == '0) begin
                        state_d = FINAL;
                    end else begin
                        zcnt_d = zcnt - ZW'(1);
                    end
                end
                FINAL: begin
                    // A pending request chains the next frame with no idle bit
                    if (req) begin
                        state_d = LEAD0;
                        n_lat_d = n_zeros;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // FINAL is never re-entered from itself, so this marks the entry edge
            if (state_d == FINAL) begin
                done_d = 1'b1;
                if (frame_cnt != CNT_MAX) begin
                    frame_cnt_d = frame_cnt + CNT_W'(1);
                end
            end
        end

        case (state_d)
            LEAD0, ZEROS: sig_d = 1'b0;
            default:      sig_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_lat     <= '0;
            zcnt      <= '0;
            sig_out   <= 1'b1;
            ack       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_d;
            n_lat     <= n_lat_d;
            zcnt      <= zcnt_d;
            sig_out   <= sig_d;
            ack       <= ack_d;
            busy      <= busy_d;
            done      <= done_d;
            frame_cnt <= frame_cnt_d;
        end
    end

`ifdef SEQGEN_DISP_EN
    // Active-low segment pattern (gfedcba) for one decimal digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0011000;
            default: seg7 = 7'b0000111;
        endcase
    endfunction

    logic [3:0] ones_d;
    logic [3:0] tens_d;

    // Split the upcoming count into decimal digits so the display tracks frame_cnt
    always_comb begin
        ones_d = 4'(frame_cnt_d % CNT_W'(10));
        tens_d = 4'(frame_cnt_d / CNT_W'(10));
    end

    // Display registers, decimal point held off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp0 <= 8'b11000000;
            disp1 <= 8'b11000000;
        end else if (ena) begin
            disp0 <= {1'b1, seg7(ones_d)};
            disp1 <= {1'b1, seg7(tens_d)};
        end
    end
`endif

endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: directed and randomized checks of sequence_generator
// against a frame-position reference model.
module tb_sequence_generator;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       req;
    logic [3:0] n_zeros;
    logic       sig_out;
    logic       ack;
    logic       busy;
    logic       done;
    logic [6:0] frame_cnt;
`ifdef SEQGEN_DISP_EN
    logic [7:0] disp0;
    logic [7:0] disp1;
    logic [6:0] seg_tab [10];
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: position within the current frame (0 = idle, 1..n+3)
    int m_pos  = 0;
    int m_n    = 0;
    int m_cnt  = 0;
    bit m_ack  = 0;
    bit m_done = 0;

    sequence_generator #(.ZW(4), .CNT_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req       (req),
        .n_zeros   (n_zeros),
        .sig_out   (sig_out),
        .ack       (ack),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
`ifdef SEQGEN_DISP_EN
        ,
        .disp0     (disp0),
        .disp1     (disp1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_sig();
        if (m_pos == 0)        return 1'b1;
        if (m_pos == 1)        return 1'b0;
        if (m_pos == 2)        return 1'b1;
        if (m_pos == m_n + 3)  return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_pos  = 0;
        m_n    = 0;
        m_cnt  = 0;
        m_ack  = 0;
        m_done = 0;
    endtask

    task automatic model_step(input bit e, input bit r, input int nz);
        int last;
        m_ack  = 0;
        m_done = 0;
        if (e) begin
            last = m_n + 3;
            if (r && (m_pos == 0 || m_pos == last)) begin
                m_pos = 1;
                m_n   = nz;
                m_ack = 1;
            end else if (m_pos == last) begin
                m_pos = 0;
            end else if (m_pos != 0) begin
                m_pos++;
            end
            if (m_pos != 0 && m_pos == m_n + 3) begin
                m_done = 1;
                if (m_cnt < 99) m_cnt++;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".sig_out"},   32'(sig_out),   32'(exp_sig()));
        check({tag, ".ack"},       32'(ack),       32'(m_ack));
        check({tag, ".done"},      32'(done),      32'(m_done));
        check({tag, ".busy"},      32'(busy),      32'(m_pos != 0));
        check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
`ifdef SEQGEN_DISP_EN
        check({tag, ".disp0"}, 32'(disp0), 32'({1'b1, seg_tab[m_cnt % 10]}));
        check({tag, ".disp1"}, 32'(disp1), 32'({1'b1, seg_tab[m_cnt / 10]}));
`endif
    endtask

    // One enabled/disabled clock: drive at negedge, sample 1 time unit after posedge
    task automatic step(input string tag, input bit e, input bit r, input int nz);
        @(negedge clk);
        ena     = e;
        req     = r;
        n_zeros = 4'(nz);
        @(posedge clk);
        model_step(e, r, nz);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ena   = 1'b0;
        req   = 1'b0;
        #2;
        model_reset();
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [0:5] exp1;
        bit         e;
        bit         r;
        int         nz;

`ifdef SEQGEN_DISP_EN
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0011000;
`endif
        rst_n   = 1'b0;
        ena     = 1'b0;
        req     = 1'b0;
        n_zeros = '0;
        #12;
        do_reset();

        // Test 1: single N=2 frame, pattern 0,1,0,0,1 then idle 1
        exp1 = 6'b010011;
        step("t1", 1'b1, 1'b1, 2);
        check("t1.bit0", 32'(sig_out), 32'(exp1[0]));
        for (int i = 1; i < 6; i++) begin
            step("t1", 1'b1, 1'b0, 9);
            check($sformatf("t1.bit%0d", i), 32'(sig_out), 32'(exp1[i]));
        end
        check("t1.frame_cnt_const", 32'(frame_cnt), 32'd1);

        // Test 2: N=0 frame, pattern 0,1,1
        step("t2", 1'b1, 1'b1, 0);
        for (int i = 0; i < 4; i++) step("t2", 1'b1, 1'b0, 0);

        // Test 3: req held with N=3, frames chain with no idle bit
        for (int i = 0; i < 18; i++) step("t3", 1'b1, 1'b1, 3);
        step("t3", 1'b1, 1'b0, 3);
        for (int i = 0; i < 6; i++) step("t3", 1'b1, 1'b0, 3);

        // Test 4: N=4, ena dropped three cycles mid-ZEROS, n_zeros changed meanwhile
        step("t4", 1'b1, 1'b1, 4);
        for (int i = 0; i < 3; i++) step("t4", 1'b1, 1'b0, 15);
        for (int i = 0; i < 3; i++) step("t4.frz", 1'b0, 1'b1, 1);
        for (int i = 0; i < 5; i++) step("t4", 1'b1, 1'b0, 7);

        // Test 5: asynchronous reset in the middle of an N=5 frame
        step("t5", 1'b1, 1'b1, 5);
        step("t5", 1'b1, 1'b0, 5);
        step("t5", 1'b1, 1'b0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t5.async.sig_out",   32'(sig_out),   32'd1);
        check("t5.async.busy",      32'(busy),      32'd0);
        check("t5.async.frame_cnt", 32'(frame_cnt), 32'd0);
        compare_all("t5.async");
        @(negedge clk);
        rst_n = 1'b1;
        step("t5.fresh", 1'b1, 1'b1, 2);
        for (int i = 0; i < 6; i++) step("t5.fresh", 1'b1, 1'b0, 2);

        // Randomized traffic with random enables, requests and lengths
        for (int i = 0; i < 1500; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) == 0);
            nz = int'($urandom_range(0, 15));
            step("rand", e, r, nz);
        end

        // Test 6: 105 back-to-back N=1 frames saturate the count at 99
        do_reset();
        for (int i = 0; i < 105 * 4; i++) step("t6", 1'b1, 1'b1, 1);
        step("t6", 1'b1, 1'b0, 1);
        step("t6", 1'b1, 1'b0, 1);
        check("t6.frame_cnt_sat", 32'(frame_cnt), 32'd99);
`ifdef SEQGEN_DISP_EN
        check("t6.disp0_9", 32'(disp0), 32'(8'b10011000));
        check("t6.disp1_9", 32'(disp1), 32'(8'b10011000));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
